// File: rtl/doodle_jump_ctrl.sv
// Vertical-motion controller for the doodle: idle -> rise -> fall -> game over, with world scroll and score.
// Optional spring boost on bounce is enabled by defining DOODLE_SPRING_EN.
module doodle_jump_ctrl #(
    parameter int Y_W      = 8,
    parameter int SCORE_W  = 16,
    parameter int START_Y  = 20,
    parameter int SCROLL_Y = 120
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               Start,
    input  logic               Ack,
    input  logic               tick,
    input  logic [Y_W-1:0]     jump_h,
    input  logic               hit,
    input  logic               spring,
    output logic [Y_W-1:0]     J,
    output logic [Y_W-1:0]     y,
    output logic [Y_W-1:0]     curr,
    output logic               scroll,
    output logic [SCORE_W-1:0] score,
    output logic               q_I,
    output logic               q_Up,
    output logic               q_Down,
    output logic               q_Done
);

    // state  | meaning
    // IDLE   | waiting for Start
    // UP     | rising one step per tick until curr reaches J
    // DOWN   | falling one step per tick; hit bounces, bottom ends the game
    // DONE   | game over, waiting for Ack
    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_UP   = 4'b0010;
    localparam logic [3:0] S_DOWN = 4'b0100;
    localparam logic [3:0] S_DONE = 4'b1000;

    localparam logic [Y_W-1:0] START_V  = Y_W'(START_Y);
    localparam logic [Y_W-1:0] SCROLL_V = Y_W'(SCROLL_Y);

    logic [3:0]     state;
    logic [3:0]     state_nxt;
    logic [Y_W-1:0] reload_j;

`ifdef DOODLE_SPRING_EN
    logic [Y_W:0] dbl_h;
    assign dbl_h    = {jump_h, 1'b0};
    assign reload_j = !spring    ? jump_h :
                      dbl_h[Y_W] ? {Y_W{1'b1}} : dbl_h[Y_W-1:0];
`else
    logic unused_spring;
    assign unused_spring = spring;
    assign reload_j      = jump_h;
`endif

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (Start) state_nxt = S_UP;
            S_UP:   if (tick && curr == J) state_nxt = S_DOWN;
            S_DOWN: begin
                if (tick) begin
                    if (hit)         state_nxt = S_UP;
                    else if (y == 0) state_nxt = S_DONE;
                end
            end
            S_DONE: if (Ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        q_I    = (state == S_IDLE);
        q_Up   = (state == S_UP);
        q_Down = (state == S_DOWN);
        q_Done = (state == S_DONE);
    end

    // Datapath: scroll is a one-cycle pulse, so it clears every cycle unless re-armed.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            J      <= '0;
            y      <= '0;
            curr   <= '0;
            score  <= '0;
            scroll <= 1'b0;
        end else begin
            scroll <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        J     <= jump_h;
                        y     <= START_V;
                        curr  <= '0;
                        score <= '0;
                    end
                end
                S_UP: begin
                    if (tick && curr != J) begin
                        curr <= curr + 1'b1;
                        if (y < SCROLL_V) begin
                            y <= y + 1'b1;
                        end else begin
                            scroll <= 1'b1;
                            if (score != {SCORE_W{1'b1}}) score <= score + 1'b1;
                        end
                    end
                end
                S_DOWN: begin
                    if (tick) begin
                        if (hit) begin
                            curr <= '0;
                            J    <= reload_j;
                        end else if (y != 0) begin
                            y <= y - 1'b1;
                            if (curr != 0) curr <= curr - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
